// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the byte-offset width derived from the data word width.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_DRAIN  = 2'd3
   } lsu_state_e;

   // Number of byte-offset bits inside one data word.
   function automatic int lsu_off(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and store replication on the way
// out, lane extraction plus zero/sign extension on the way back.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OFF        = lsu_off(DATA_WIDTH)
) (
   input  logic [OFF-1:0]          offset_i,
   input  logic [1:0]              size_i,
   input  logic                    signed_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH-1:0]   rdata_i,
   output logic [DATA_WIDTH/8-1:0] be_o,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic [DATA_WIDTH-1:0]   rdata_o
);
   localparam int NB = DATA_WIDTH / 8;

   logic [NB-1:0]         mask;
   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      mask = '1;
      case (size_i)
         SZ_BYTE: mask = NB'(1);
         SZ_HALF: mask = NB'(3);
         default: mask = '1;
      endcase
      be_o = mask << offset_i;

      wdata_o = '0;
      for (int i = 0; i < NB; i++) begin
         case (size_i)
            SZ_BYTE: wdata_o[8*i +: 8] = wdata_i[7:0];
            SZ_HALF: wdata_o[8*i +: 8] = wdata_i[8*(i%2) +: 8];
            default: wdata_o[8*i +: 8] = wdata_i[8*i +: 8];
         endcase
      end

      shifted = rdata_i >> {offset_i, 3'b000};
      case (size_i)
         SZ_BYTE: rdata_o = {{(DATA_WIDTH-8){signed_i & shifted[7]}}, shifted[7:0]};
         SZ_HALF: rdata_o = {{(DATA_WIDTH-16){signed_i & shifted[15]}}, shifted[15:0]};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a req/gnt/rvalid
// memory port, with misalignment detection, flush, and per-phase timeouts.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_SIZE  = 12,
   parameter int TIMEOUT    = 15
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_valid,
   output logic                              o_ready,
   input  logic                              i_wr_rd,
   input  logic [1:0]                        i_size,
   input  logic                              i_signed,
   input  logic [ADDR_SIZE-1:0]              i_addr,
   input  logic [DATA_WIDTH-1:0]             i_wdata,
   input  logic                              i_flush,
   output logic                              o_rd_valid,
   output logic [DATA_WIDTH-1:0]             o_rd_data,
   output logic                              o_done,
   output logic                              o_misalign,
   output logic                              o_timeout,
   output logic                              o_mem_req,
   output logic                              o_mem_we,
   output logic [ADDR_SIZE-lsu_off(DATA_WIDTH)-1:0] o_mem_addr,
   output logic [DATA_WIDTH/8-1:0]           o_mem_be,
   output logic [DATA_WIDTH-1:0]             o_mem_wdata,
   input  logic                              i_mem_gnt,
   input  logic                              i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0]             i_mem_rdata
);
   localparam int OFF = lsu_off(DATA_WIDTH);
   localparam int CW  = $clog2(TIMEOUT + 1);

   lsu_state_e            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0]  addr_q;
   logic [1:0]            size_q;
   logic                  signed_q, wr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rd_data_q;
   logic                  rd_valid_q, rd_valid_d, done_q, done_d;
   logic                  misalign_q, misalign_d, timeout_q, timeout_d;
   logic                  accept, misaligned_in, timed_out;
   logic [DATA_WIDTH/8-1:0] lane_be;
   logic [DATA_WIDTH-1:0] lane_wdata, lane_rdata;

   lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .offset_i (addr_q[OFF-1:0]),
      .size_i   (size_q),
      .signed_i (signed_q),
      .wdata_i  (wdata_q),
      .rdata_i  (i_mem_rdata),
      .be_o     (lane_be),
      .wdata_o  (lane_wdata),
      .rdata_o  (lane_rdata)
   );

   assign accept        = (state_q == ST_IDLE) && i_valid;
   assign misaligned_in = (i_size == SZ_BAD)
                       || ((i_size == SZ_HALF) && i_addr[0])
                       || ((i_size == SZ_WORD) && (i_addr[OFF-1:0] != '0));
   // The TIMEOUT-th cycle spent in the current state.
   assign timed_out     = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               if (misaligned_in) misalign_d = 1'b1;
               else               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // Flush wins over gnt, but a granted store has already been committed.
            if (i_flush) begin
               if (i_mem_gnt && wr_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (i_mem_gnt) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (i_mem_gnt) begin
               if (wr_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_WAIT_R;
               end
            end else if (timed_out) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
         end
         ST_WAIT_R: begin
            if (i_flush) begin
               state_d = i_mem_rvalid ? ST_IDLE : ST_DRAIN;
            end else if (i_mem_rvalid) begin
               state_d    = ST_IDLE;
               rd_valid_d = 1'b1;
               done_d     = 1'b1;
            end else if (timed_out) begin
               state_d   = ST_DRAIN;
               timeout_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (i_mem_rvalid || timed_out) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_d = '0;
      else                                              cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         size_q     <= '0;
         signed_q   <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
         if (accept) begin
            addr_q   <= i_addr;
            size_q   <= i_size;
            signed_q <= i_signed;
            wr_q     <= i_wr_rd;
            wdata_q  <= i_wdata;
         end
         if (rd_valid_d) rd_data_q <= lane_rdata;
      end
   end

   assign o_ready     = (state_q == ST_IDLE);
   assign o_mem_req   = (state_q == ST_REQ);
   assign o_mem_we    = o_mem_req && wr_q;
   assign o_mem_addr  = addr_q[ADDR_SIZE-1:OFF];
   assign o_mem_be    = o_mem_req ? lane_be    : '0;
   assign o_mem_wdata = o_mem_req ? lane_wdata : '0;
   assign o_rd_valid  = rd_valid_q;
   assign o_rd_data   = rd_data_q;
   assign o_done      = done_q;
   assign o_misalign  = misalign_q;
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus
// hand-written sequences for wait states, timeout, flush and reset.
module tb_load_store_unit;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0, i_wr_rd = 1'b0, i_signed = 1'b0, i_flush = 1'b0;
   logic [1:0]  i_size = 2'd0;
   logic [11:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        o_ready, o_rd_valid, o_done, o_misalign, o_timeout;
   logic [31:0] o_rd_data;
   logic        o_mem_req, o_mem_we;
   logic [9:0]  o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
   logic [31:0] i_mem_rdata = '0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rd = '0;

   always #5 i_clk = ~i_clk;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_SIZE(12), .TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_valid(i_valid), .o_ready(o_ready), .i_wr_rd(i_wr_rd), .i_size(i_size),
      .i_signed(i_signed), .i_addr(i_addr), .i_wdata(i_wdata), .i_flush(i_flush),
      .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_done(o_done),
      .o_misalign(o_misalign), .o_timeout(o_timeout),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  be;
      logic [9:0]  waddr;
      logic [31:0] mwdata;
      logic [31:0] rd;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [11:0] addr, input logic [31:0] wdata);
      i_valid = 1'b1; i_wr_rd = wr; i_size = size; i_signed = sgn;
      i_addr = addr; i_wdata = wdata;
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        wr    size  sgn   addr     wdata         rdata         mis   be       waddr    mwdata        rd
      vt[0]  = '{1'b0, 2'd0, 1'b1, 12'h006, 32'h0,        32'h12F45678, 1'b0, 4'b0100, 10'h001, 32'h0,        32'hFFFFFFF4};
      vt[1]  = '{1'b0, 2'd0, 1'b0, 12'h006, 32'h0,        32'h12F45678, 1'b0, 4'b0100, 10'h001, 32'h0,        32'h000000F4};
      vt[2]  = '{1'b0, 2'd1, 1'b1, 12'h00A, 32'h0,        32'h80017FFF, 1'b0, 4'b1100, 10'h002, 32'h0,        32'hFFFF8001};
      vt[3]  = '{1'b0, 2'd1, 1'b0, 12'h004, 32'h0,        32'h12349ABC, 1'b0, 4'b0011, 10'h001, 32'h0,        32'h00009ABC};
      vt[4]  = '{1'b0, 2'd2, 1'b1, 12'hFFC, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 10'h3FF, 32'h0,        32'hDEADBEEF};
      vt[5]  = '{1'b0, 2'd0, 1'b1, 12'h001, 32'h0,        32'h00007F00, 1'b0, 4'b0010, 10'h000, 32'h0,        32'h0000007F};
      vt[6]  = '{1'b0, 2'd0, 1'b1, 12'h007, 32'h0,        32'h80123456, 1'b0, 4'b1000, 10'h001, 32'h0,        32'hFFFFFF80};
      vt[7]  = '{1'b1, 2'd0, 1'b0, 12'h013, 32'h000000A5, 32'h0,        1'b0, 4'b1000, 10'h004, 32'hA5A5A5A5, 32'h0};
      vt[8]  = '{1'b1, 2'd1, 1'b0, 12'h00A, 32'h0000BEEF, 32'h0,        1'b0, 4'b1100, 10'h002, 32'hBEEFBEEF, 32'h0};
      vt[9]  = '{1'b1, 2'd2, 1'b0, 12'h020, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 10'h008, 32'hCAFEF00D, 32'h0};
      vt[10] = '{1'b0, 2'd2, 1'b0, 12'h002, 32'h0,        32'h0,        1'b1, 4'b0000, 10'h000, 32'h0,        32'h0};
      vt[11] = '{1'b1, 2'd1, 1'b0, 12'h005, 32'h0,        32'h0,        1'b1, 4'b0000, 10'h000, 32'h0,        32'h0};
      vt[12] = '{1'b0, 2'd3, 1'b0, 12'h000, 32'h0,        32'h0,        1'b1, 4'b0000, 10'h000, 32'h0,        32'h0};

      // Reset values
      #12;
      chk("rst_req", {31'b0, o_mem_req}, 32'd0);
      chk("rst_we", {31'b0, o_mem_we}, 32'd0);
      chk("rst_pulses", {28'b0, o_rd_valid, o_done, o_misalign, o_timeout}, 32'd0);
      chk("rst_rd_data", o_rd_data, 32'd0);
      chk("rst_mem_addr", {22'b0, o_mem_addr}, 32'd0);
      chk("rst_mem_be", {28'b0, o_mem_be}, 32'd0);
      chk("rst_mem_wdata", o_mem_wdata, 32'd0);
      tick();
      i_reset = 1'b0;
      tick();
      chk("rst_ready", {31'b0, o_ready}, 32'd1);

      // Single accesses, gnt and rvalid each on the first possible cycle
      for (int k = 0; k < 13; k++) begin
         issue(vt[k].wr, vt[k].size, vt[k].sgn, vt[k].addr, vt[k].wdata);
         if (vt[k].mis) begin
            chk($sformatf("v%0d_misalign", k), {31'b0, o_misalign}, 32'd1);
            chk($sformatf("v%0d_noreq", k), {31'b0, o_mem_req}, 32'd0);
            chk($sformatf("v%0d_ready", k), {31'b0, o_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d_mis_drop", k), {31'b0, o_misalign, o_mem_req}, 32'd0);
         end else begin
            chk($sformatf("v%0d_req", k), {31'b0, o_mem_req}, 32'd1);
            chk($sformatf("v%0d_we", k), {31'b0, o_mem_we}, {31'b0, vt[k].wr});
            chk($sformatf("v%0d_be", k), {28'b0, o_mem_be}, {28'b0, vt[k].be});
            chk($sformatf("v%0d_waddr", k), {22'b0, o_mem_addr}, {22'b0, vt[k].waddr});
            if (vt[k].wr) chk($sformatf("v%0d_wdata", k), o_mem_wdata, vt[k].mwdata);
            i_mem_gnt = 1'b1;
            tick();
            i_mem_gnt = 1'b0;
            if (vt[k].wr) begin
               chk($sformatf("v%0d_done", k), {31'b0, o_done, o_ready, o_rd_valid}, 32'b110);
            end else begin
               chk($sformatf("v%0d_wait", k), {31'b0, o_ready, o_done, o_mem_req}, 32'b000);
               i_mem_rvalid = 1'b1;
               i_mem_rdata = vt[k].rdata;
               tick();
               i_mem_rvalid = 1'b0;
               exp_rd = vt[k].rd;
               chk($sformatf("v%0d_rvalid_done", k), {31'b0, o_rd_valid, o_done}, 32'b11);
               chk($sformatf("v%0d_rdata", k), o_rd_data, exp_rd);
               i_mem_rdata = 32'h5555AAAA;
            end
            tick();
            chk($sformatf("v%0d_quiet", k), {31'b0, o_rd_valid, o_done}, 32'b00);
            chk($sformatf("v%0d_hold", k), o_rd_data, exp_rd);
         end
      end

      // Half store with gnt in the third REQ cycle
      issue(1'b1, 2'd1, 1'b0, 12'h00A, 32'h0000BEEF);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("ws_req%0d", c), {31'b0, o_mem_req, o_done}, 32'b10);
         chk($sformatf("ws_be%0d", c), {28'b0, o_mem_be}, 32'b1100);
         chk($sformatf("ws_wdata%0d", c), o_mem_wdata, 32'hBEEFBEEF);
         i_mem_gnt = (c == 2);
         tick();
      end
      i_mem_gnt = 1'b0;
      chk("ws_done", {31'b0, o_done, o_mem_req}, 32'b10);
      tick();
      chk("ws_done_once", {31'b0, o_done}, 32'd0);

      // REQ timeout: gnt never arrives
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("to_req%0d", c), {31'b0, o_mem_req, o_timeout}, 32'b10);
         tick();
      end
      chk("to_pulse", {29'b0, o_timeout, o_mem_req, o_ready}, 32'b101);
      tick();
      chk("to_drop", {31'b0, o_timeout}, 32'd0);

      // rvalid in IDLE is ignored
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
      tick();
      i_mem_rvalid = 1'b0;
      tick();
      chk("idle_rvalid", {31'b0, o_rd_valid, o_done}, 32'b00);
      chk("idle_rvalid_hold", o_rd_data, exp_rd);

      // Flush in WAIT_R, rvalid two cycles later
      issue(1'b0, 2'd0, 1'b0, 12'h000, 32'h0);
      i_mem_gnt = 1'b1; tick(); i_mem_gnt = 1'b0;
      i_flush = 1'b1; tick(); i_flush = 1'b0;
      chk("fl_drain", {31'b0, o_ready, o_rd_valid}, 32'b00);
      tick();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h000000AA;
      tick();
      i_mem_rvalid = 1'b0;
      chk("fl_after", {29'b0, o_ready, o_rd_valid, o_done}, 32'b100);
      chk("fl_hold", o_rd_data, exp_rd);
      issue(1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
      chk("fl_next_addr", {22'b0, o_mem_addr}, 32'h010);
      i_mem_gnt = 1'b1; tick(); i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BADF00D; tick(); i_mem_rvalid = 1'b0;
      exp_rd = 32'h0BADF00D;
      chk("fl_next_data", o_rd_data, exp_rd);
      chk("fl_next_valid", {31'b0, o_rd_valid}, 32'd1);
      tick();

      // DRAIN with no rvalid times out silently
      issue(1'b0, 2'd1, 1'b0, 12'h002, 32'h0);
      i_mem_gnt = 1'b1; tick(); i_mem_gnt = 1'b0;
      i_flush = 1'b1; tick(); i_flush = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("dto_busy%0d", c), {31'b0, o_ready, o_timeout}, 32'b00);
         tick();
      end
      chk("dto_idle", {29'b0, o_ready, o_timeout, o_rd_valid}, 32'b100);

      // Flush in REQ: no grant drops the store; with grant the store still retires
      issue(1'b1, 2'd2, 1'b0, 12'h100, 32'h11223344);
      i_flush = 1'b1; tick(); i_flush = 1'b0;
      chk("frq_drop", {29'b0, o_mem_req, o_ready, o_done}, 32'b010);
      issue(1'b1, 2'd2, 1'b0, 12'h104, 32'h11223344);
      i_flush = 1'b1; i_mem_gnt = 1'b1; tick(); i_flush = 1'b0; i_mem_gnt = 1'b0;
      chk("frq_gnt_store", {30'b0, o_done, o_ready}, 32'b11);
      tick();
      issue(1'b0, 2'd2, 1'b0, 12'h108, 32'h0);
      i_flush = 1'b1; i_mem_gnt = 1'b1; tick(); i_flush = 1'b0; i_mem_gnt = 1'b0;
      chk("frq_gnt_load", {29'b0, o_ready, o_mem_req, o_done}, 32'b000);
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77777777; tick(); i_mem_rvalid = 1'b0;
      chk("frq_gnt_load_end", {29'b0, o_ready, o_rd_valid, o_done}, 32'b100);
      chk("frq_hold", o_rd_data, exp_rd);

      // Reset asserted while waiting for read data
      issue(1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
      i_mem_gnt = 1'b1; tick(); i_mem_gnt = 1'b0;
      chk("mr_wait", {31'b0, o_ready}, 32'd0);
      i_reset = 1'b1;
      #1;
      chk("mr_async", {30'b0, o_mem_req, o_ready}, 32'b01);
      tick();
      i_reset = 1'b0;
      tick();
      chk("mr_release", {29'b0, o_mem_req, o_ready, o_rd_valid}, 32'b010);
      chk("mr_rd_clear", o_rd_data, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
